// File: rtl/rice_core_id_queue.sv
// Decode stage with a DEPTH-entry buffer of pre-decoded instructions between IF and EX.
// Each instruction is decoded on enqueue. The head entry is held back on a load-use hazard.
module rice_core_id_queue #(
    parameter int unsigned XLEN             = 32,
    parameter int unsigned DEPTH            = 4,
    parameter bit          ENABLE_INTERLOCK = 1'b1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_flush,
    input  logic            i_if_valid,
    output logic            o_if_ready,
    input  logic [XLEN-1:0] i_if_pc,
    input  logic [31:0]     i_if_inst,
    output logic            o_id_valid,
    input  logic            i_id_ready,
    output logic [XLEN-1:0] o_id_pc,
    output logic [31:0]     o_id_inst,
    output logic [4:0]      o_id_rs1,
    output logic [4:0]      o_id_rs2,
    output logic [4:0]      o_id_rd,
    output logic [XLEN-1:0] o_id_imm,
    output logic            o_id_illegal,
    input  logic            i_ex_load_valid,
    input  logic [4:0]      i_ex_load_rd,
    output logic [15:0]     o_hazard_count
);

    localparam int unsigned IdxW = $clog2(DEPTH);
    localparam int unsigned PtrW = IdxW + 1;

    localparam logic [6:0] OpLui     = 7'b0110111;
    localparam logic [6:0] OpAuipc   = 7'b0010111;
    localparam logic [6:0] OpJal     = 7'b1101111;
    localparam logic [6:0] OpJalr    = 7'b1100111;
    localparam logic [6:0] OpBranch  = 7'b1100011;
    localparam logic [6:0] OpLoad    = 7'b0000011;
    localparam logic [6:0] OpStore   = 7'b0100011;
    localparam logic [6:0] OpOpImm   = 7'b0010011;
    localparam logic [6:0] OpOp      = 7'b0110011;
    localparam logic [6:0] OpMiscMem = 7'b0001111;
    localparam logic [6:0] OpSystem  = 7'b1110011;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     inst;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] imm;
        logic            illegal;
    } entry_t;

    entry_t          mem_q [DEPTH];
    entry_t          mem_d [DEPTH];
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [15:0]     hazard_count_q, hazard_count_d;

    entry_t          dec;
    entry_t          head;
    logic            empty;
    logic            full;
    logic            hazard;
    logic            enq;
    logic            deq;
    logic [31:0]     imm32;

    assign empty = (rd_ptr_q == wr_ptr_q);
    assign full  = (rd_ptr_q[IdxW-1:0] == wr_ptr_q[IdxW-1:0]) &&
                   (rd_ptr_q[IdxW] != wr_ptr_q[IdxW]);
    assign head  = mem_q[rd_ptr_q[IdxW-1:0]];

    assign hazard = ENABLE_INTERLOCK && !empty && i_ex_load_valid && (i_ex_load_rd != 5'd0) &&
                    ((i_ex_load_rd == head.rs1) || (i_ex_load_rd == head.rs2));

    assign o_if_ready = !full && !i_rst;
    assign o_id_valid = !empty && !hazard && !i_flush;

    assign enq = i_if_valid && o_if_ready && !i_flush;
    assign deq = o_id_valid && i_id_ready;

    // Every listed opcode ends in 2'b11, so non-32-bit encodings fall into the default arm.
    always_comb begin
        dec      = '0;
        dec.pc   = i_if_pc;
        dec.inst = i_if_inst;
        imm32    = '0;
        case (i_if_inst[6:0])
            OpJalr, OpLoad, OpOpImm, OpMiscMem, OpSystem: begin
                dec.rs1 = i_if_inst[19:15];
                dec.rd  = i_if_inst[11:7];
                imm32   = {{20{i_if_inst[31]}}, i_if_inst[31:20]};
            end
            OpStore: begin
                dec.rs1 = i_if_inst[19:15];
                dec.rs2 = i_if_inst[24:20];
                imm32   = {{20{i_if_inst[31]}}, i_if_inst[31:25], i_if_inst[11:7]};
            end
            OpBranch: begin
                dec.rs1 = i_if_inst[19:15];
                dec.rs2 = i_if_inst[24:20];
                imm32   = {{19{i_if_inst[31]}}, i_if_inst[31], i_if_inst[7],
                           i_if_inst[30:25], i_if_inst[11:8], 1'b0};
            end
            OpLui, OpAuipc: begin
                dec.rd = i_if_inst[11:7];
                imm32  = {i_if_inst[31:12], 12'h000};
            end
            OpJal: begin
                dec.rd = i_if_inst[11:7];
                imm32  = {{11{i_if_inst[31]}}, i_if_inst[31], i_if_inst[19:12],
                          i_if_inst[20], i_if_inst[30:21], 1'b0};
            end
            OpOp: begin
                dec.rs1 = i_if_inst[19:15];
                dec.rs2 = i_if_inst[24:20];
                dec.rd  = i_if_inst[11:7];
            end
            default: dec.illegal = 1'b1;
        endcase
        dec.imm = XLEN'($signed(imm32));
    end

    always_comb begin
        mem_d          = mem_q;
        rd_ptr_d       = rd_ptr_q;
        wr_ptr_d       = wr_ptr_q;
        hazard_count_d = hazard_count_q;
        if (hazard && (hazard_count_q != 16'hFFFF)) begin
            hazard_count_d = hazard_count_q + 16'd1;
        end
        if (i_flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (enq) begin
                mem_d[wr_ptr_q[IdxW-1:0]] = dec;
                wr_ptr_d                  = wr_ptr_q + PtrW'(1);
            end
            if (deq) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rd_ptr_q       <= '0;
            wr_ptr_q       <= '0;
            hazard_count_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            rd_ptr_q       <= rd_ptr_d;
            wr_ptr_q       <= wr_ptr_d;
            hazard_count_q <= hazard_count_d;
            mem_q          <= mem_d;
        end
    end

    assign o_id_pc        = head.pc;
    assign o_id_inst      = head.inst;
    assign o_id_rs1       = head.rs1;
    assign o_id_rs2       = head.rs2;
    assign o_id_rd        = head.rd;
    assign o_id_imm       = head.imm;
    assign o_id_illegal   = head.illegal;
    assign o_hazard_count = hazard_count_q;

endmodule

// File: tb/tb_rice_core_id_queue.sv
// Bench for rice_core_id_queue: directed cases plus random traffic against a queue-based model.
module tb_rice_core_id_queue;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;

    logic        clk;
    logic        rst, flush, if_valid, id_ready, ld_v;
    logic [4:0]  ld_rd;
    logic [31:0] if_pc, if_inst;
    logic        if_ready, id_valid, id_illegal;
    logic [31:0] id_pc, id_inst, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [15:0] hcount;

    logic        b_rst, b_flush, b_if_valid, b_id_ready, b_ld_v;
    logic [4:0]  b_ld_rd;
    logic [63:0] b_if_pc, b_id_pc, b_id_imm;
    logic [31:0] b_if_inst, b_id_inst;
    logic        b_if_ready, b_id_valid, b_id_illegal;
    logic [4:0]  b_id_rs1, b_id_rs2, b_id_rd;
    logic [15:0] b_hcount;

    rice_core_id_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .ENABLE_INTERLOCK(1'b1)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_if_valid(if_valid), .o_if_ready(if_ready),
        .i_if_pc(if_pc), .i_if_inst(if_inst), .o_id_valid(id_valid), .i_id_ready(id_ready),
        .o_id_pc(id_pc), .o_id_inst(id_inst), .o_id_rs1(id_rs1), .o_id_rs2(id_rs2),
        .o_id_rd(id_rd), .o_id_imm(id_imm), .o_id_illegal(id_illegal),
        .i_ex_load_valid(ld_v), .i_ex_load_rd(ld_rd), .o_hazard_count(hcount)
    );

    rice_core_id_queue #(.XLEN(64), .DEPTH(2), .ENABLE_INTERLOCK(1'b0)) u_dut64 (
        .i_clk(clk), .i_rst(b_rst), .i_flush(b_flush), .i_if_valid(b_if_valid),
        .o_if_ready(b_if_ready), .i_if_pc(b_if_pc), .i_if_inst(b_if_inst),
        .o_id_valid(b_id_valid), .i_id_ready(b_id_ready), .o_id_pc(b_id_pc),
        .o_id_inst(b_id_inst), .o_id_rs1(b_id_rs1), .o_id_rs2(b_id_rs2), .o_id_rd(b_id_rd),
        .o_id_imm(b_id_imm), .o_id_illegal(b_id_illegal), .i_ex_load_valid(b_ld_v),
        .i_ex_load_rd(b_ld_rd), .o_hazard_count(b_hcount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    ent_t q[$];
    int   cnt_m = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Instruction classification and fields straight from the ISA encoding rules.
    function automatic void ref_decode(input logic [31:0] w, output logic [4:0] rs1,
                                       output logic [4:0] rs2, output logic [4:0] rd,
                                       output logic [63:0] imm, output logic ill);
        byte t;
        case (w[6:0])
            7'h67, 7'h03, 7'h13, 7'h0F, 7'h73: t = "I";
            7'h23:                             t = "S";
            7'h63:                             t = "B";
            7'h37, 7'h17:                      t = "U";
            7'h6F:                             t = "J";
            7'h33:                             t = "R";
            default:                           t = "X";
        endcase
        if (w[1:0] != 2'b11) t = "X";
        rs1 = (t inside {"I", "S", "B", "R"}) ? w[19:15] : 5'd0;
        rs2 = (t inside {"S", "B", "R"}) ? w[24:20] : 5'd0;
        rd  = (t inside {"I", "U", "J", "R"}) ? w[11:7] : 5'd0;
        ill = (t == "X");
        case (t)
            "I":     imm = longint'($signed(w)) >>> 20;
            "S":     imm = (longint'($signed(w)) >>> 25) * 32 + longint'(w[11:7]);
            "B":     imm = (longint'($signed(w)) >>> 31) * 4096 + longint'(w[7]) * 2048 +
                           longint'(w[30:25]) * 32 + longint'(w[11:8]) * 2;
            "U":     imm = longint'($signed(w & 32'hFFFF_F000));
            "J":     imm = (longint'($signed(w)) >>> 31) * 1048576 +
                           longint'(w[19:12]) * 4096 + longint'(w[20]) * 2048 +
                           longint'(w[30:21]) * 2;
            default: imm = 64'd0;
        endcase
    endfunction

    // One cycle: check the settled outputs against the model, then advance model and DUT.
    task automatic step();
        logic [4:0]  r1, r2, rdd;
        logic [63:0] im;
        logic        il, hz, ev, er;
        #3;
        r1 = 5'd0; r2 = 5'd0; rdd = 5'd0; im = '0; il = 1'b0;
        if (q.size() > 0) ref_decode(q[0].inst, r1, r2, rdd, im, il);
        hz = (q.size() > 0) && ld_v && (ld_rd != 5'd0) && ((ld_rd == r1) || (ld_rd == r2));
        ev = (q.size() > 0) && !hz && !flush;
        er = (q.size() < DEPTH) && !rst;
        chk("if_ready", 64'(if_ready), 64'(er));
        chk("id_valid", 64'(id_valid), 64'(ev));
        chk("hazard_count", 64'(hcount), 64'(cnt_m));
        if (ev) begin
            chk("pc", 64'(id_pc), 64'(q[0].pc));
            chk("inst", 64'(id_inst), 64'(q[0].inst));
            chk("rs1", 64'(id_rs1), 64'(r1));
            chk("rs2", 64'(id_rs2), 64'(r2));
            chk("rd", 64'(id_rd), 64'(rdd));
            chk("imm", 64'(id_imm), 64'(im[XLEN-1:0]));
            chk("illegal", 64'(id_illegal), 64'(il));
        end
        @(posedge clk);
        if (rst) begin
            q.delete();
            cnt_m = 0;
        end else begin
            if (hz && cnt_m < 65535) cnt_m++;
            if (flush) begin
                q.delete();
            end else begin
                if (ev && id_ready) void'(q.pop_front());
                if (if_valid && er) q.push_back('{pc: if_pc, inst: if_inst});
            end
        end
        #1;
    endtask

    task automatic offer(input logic [31:0] pc, input logic [31:0] inst);
        if_valid = 1'b1;
        if_pc    = pc;
        if_inst  = inst;
    endtask

    logic [31:0] opcodes [12];
    logic [31:0] w;

    initial begin
        opcodes = '{32'h37, 32'h17, 32'h6F, 32'h67, 32'h63, 32'h03, 32'h23, 32'h13, 32'h33,
                    32'h0F, 32'h73, 32'h5B};
        rst = 1'b1; flush = 1'b0; if_valid = 1'b0; id_ready = 1'b0; ld_v = 1'b0;
        ld_rd = 5'd0; if_pc = '0; if_inst = '0;
        b_rst = 1'b1; b_flush = 1'b0; b_if_valid = 1'b0; b_id_ready = 1'b0; b_ld_v = 1'b0;
        b_ld_rd = 5'd0; b_if_pc = '0; b_if_inst = '0;

        step();
        step();
        rst = 1'b0;
        #2;
        chk("rst_valid", 64'(id_valid), 64'd0);
        chk("rst_ready", 64'(if_ready), 64'd1);
        chk("rst_fields", {id_pc, id_inst} | 64'({id_rs1, id_rs2, id_rd, id_illegal}) |
            64'(id_imm), 64'd0);
        chk("rst_hcount", 64'(hcount), 64'd0);

        // addi x1,x0,-1
        offer(32'h100, 32'hFFF0_0093);
        step();
        if_valid = 1'b0;
        #2;
        chk("addi_valid", 64'(id_valid), 64'd1);
        chk("addi_rd", 64'(id_rd), 64'd1);
        chk("addi_rs", 64'({id_rs1, id_rs2}), 64'd0);
        chk("addi_imm", 64'(id_imm), 64'hFFFF_FFFF);
        chk("addi_pc", 64'(id_pc), 64'h100);
        step();
        id_ready = 1'b1;
        step();
        id_ready = 1'b0;

        // sw x2,8(x1) followed by an all-zero word
        offer(32'h104, 32'h0020_A423);
        step();
        offer(32'h108, 32'h0000_0000);
        step();
        if_valid = 1'b0;
        #2;
        chk("sw_rs1", 64'(id_rs1), 64'd1);
        chk("sw_rs2", 64'(id_rs2), 64'd2);
        chk("sw_rd", 64'(id_rd), 64'd0);
        chk("sw_imm", 64'(id_imm), 64'd8);
        chk("sw_illegal", 64'(id_illegal), 64'd0);
        id_ready = 1'b1;
        step();
        #2;
        chk("zero_illegal", 64'(id_illegal), 64'd1);
        chk("zero_fields", 64'({id_rs1, id_rs2, id_rd}) | 64'(id_imm), 64'd0);
        step();
        id_ready = 1'b0;

        // Fill past capacity with EX stalled, then drain
        for (int i = 0; i <= DEPTH; i++) begin
            offer(32'h200 + 32'(i * 4), 32'h0000_0013 | (32'(i) << 20));
            step();
        end
        if_valid = 1'b0;
        #2;
        chk("full_ready", 64'(if_ready), 64'd0);
        id_ready = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) step();

        // Load-use stall: add x6,x5,x7 behind a load to x5
        ld_v = 1'b1;
        ld_rd = 5'd5;
        offer(32'h300, 32'h0072_8333);
        step();
        if_valid = 1'b0;
        for (int i = 0; i < 3; i++) step();
        #2;
        chk("hazard_3cyc", 64'(hcount), 64'd3);
        ld_rd = 5'd0;
        step();
        ld_v = 1'b0;
        id_ready = 1'b0;

        // Flush with three entries buffered and a fetch offered
        for (int i = 0; i < 3; i++) begin
            offer(32'h400 + 32'(i * 4), 32'h0000_0033);
            step();
        end
        offer(32'h40C, 32'h0000_0013);
        flush = 1'b1;
        step();
        flush = 1'b0;
        if_valid = 1'b0;
        #2;
        chk("flush_empty", 64'(id_valid), 64'd0);
        step();

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            w = $urandom();
            w[6:0] = opcodes[$urandom_range(0, 11)][6:0];
            if ($urandom_range(0, 15) == 0) w[1:0] = 2'($urandom_range(0, 2));
            w[19:15] = 5'($urandom_range(0, 3));
            w[24:20] = 5'($urandom_range(0, 3));
            rst      = ($urandom_range(0, 99) == 0);
            flush    = ($urandom_range(0, 99) < 3);
            if_valid = ($urandom_range(0, 9) < 7);
            id_ready = ($urandom_range(0, 9) < 6);
            ld_v     = ($urandom_range(0, 9) < 3);
            ld_rd    = 5'($urandom_range(0, 3));
            if_pc    = 32'($urandom()) & ~32'h3;
            if_inst  = w;
            step();
        end
        rst = 1'b0; flush = 1'b0; if_valid = 1'b0; ld_v = 1'b0;

        // 64-bit datapath, interlock disabled
        @(posedge clk);
        #1;
        b_rst = 1'b0;
        b_if_valid = 1'b1;
        b_if_pc = 64'h1000;
        b_if_inst = 32'h8000_00B7;
        @(posedge clk);
        #1;
        b_if_inst = 32'h0072_8333;
        #1;
        chk("x64_valid", 64'(b_id_valid), 64'd1);
        chk("x64_lui_imm", b_id_imm, 64'hFFFF_FFFF_8000_0000);
        chk("x64_lui_rd", 64'(b_id_rd), 64'd1);
        chk("x64_pc", b_id_pc, 64'h1000);
        b_id_ready = 1'b1;
        @(posedge clk);
        #1;
        b_if_valid = 1'b0;
        b_id_ready = 1'b0;
        b_ld_v = 1'b1;
        b_ld_rd = 5'd5;
        #1;
        chk("x64_nostall_valid", 64'(b_id_valid), 64'd1);
        chk("x64_nostall_rs1", 64'(b_id_rs1), 64'd5);
        @(posedge clk);
        #1;
        chk("x64_hcount", 64'(b_hcount), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
